// File: rtl/id_hazard_sequencer.sv
// Decode-stage stall/flush sequencer. Detects load-use and branch-operand
// hazards against ID/EX and EX/MEM, holds PC and IF/ID while injecting
// bubbles into ID/EX, flushes IF/ID when a control transfer leaves ID, and
// keeps a saturating count of stall cycles.
//
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   IF_IDRs/Rt/UsesRt               source registers of the instruction in ID
//   IF_IDBranch/JR/Jump, BranchTaken control-transfer class and branch outcome
//   ID_EXDst/RegWrite/MemRead       producer in EX
//   EX_MEMDst/RegWrite/MemRead      producer in MEM
//   PCWrite, IF_IDWrite             front-end load enables (combinational)
//   Stall                           bubble into ID/EX (combinational)
//   IF_IDFlush                      nop into IF/ID next edge (combinational)
//   Busy                            sequencer is in the STALL state
//   StallCycles                     saturating count of Stall=1 cycles
module id_hazard_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IF_IDRs,
    input  logic [4:0]       IF_IDRt,
    input  logic             IF_IDUsesRt,
    input  logic             IF_IDBranch,
    input  logic             IF_IDJR,
    input  logic             IF_IDJump,
    input  logic             BranchTaken,
    input  logic [4:0]       ID_EXDst,
    input  logic             ID_EXRegWrite,
    input  logic             ID_EXMemRead,
    input  logic [4:0]       EX_MEMDst,
    input  logic             EX_MEMRegWrite,
    input  logic             EX_MEMMemRead,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             Stall,
    output logic             IF_IDFlush,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int unsigned CNT_SEQ_W = 2;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_SEQ_W-1:0] cnt, cnt_nxt;
    logic [CNT_SEQ_W-1:0] need;
    logic                 ctrl;
    logic                 match_ex;
    logic                 match_mem;

    // Source matches; $0 never produces a hazard, rt only counts when read.
    assign match_ex  = ID_EXRegWrite &&
                       (((ID_EXDst == IF_IDRs) && (IF_IDRs != 5'd0)) ||
                        (IF_IDUsesRt && (ID_EXDst == IF_IDRt) && (IF_IDRt != 5'd0)));
    assign match_mem = EX_MEMRegWrite &&
                       (((EX_MEMDst == IF_IDRs) && (IF_IDRs != 5'd0)) ||
                        (IF_IDUsesRt && (EX_MEMDst == IF_IDRt) && (IF_IDRt != 5'd0)));
    assign ctrl      = IF_IDBranch || IF_IDJR;

    // Required stall length; the first matching rule gives the longest stall.
    always_comb begin
        need = 2'd0;
        if (ctrl && ID_EXMemRead && match_ex) begin
            need = 2'd2;
        end else if (ctrl && match_ex) begin
            need = 2'd1;
        end else if (ctrl && EX_MEMMemRead && match_mem) begin
            need = 2'd1;
        end else if (!ctrl && ID_EXMemRead && match_ex) begin
            need = 2'd1;
        end
    end

    // Next state and combinational pipeline controls.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        PCWrite    = 1'b1;
        IF_IDWrite = 1'b1;
        Stall      = 1'b0;
        IF_IDFlush = 1'b0;
        Busy       = 1'b0;
        if (Reset) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        PCWrite    = 1'b0;
                        IF_IDWrite = 1'b0;
                        Stall      = 1'b1;
                        if (need == 2'd2) begin
                            state_nxt = STALL;
                            cnt_nxt   = 2'd1;
                        end
                    end else begin
                        IF_IDFlush = IF_IDJump || IF_IDJR || (IF_IDBranch && BranchTaken);
                    end
                end
                STALL: begin
                    PCWrite    = 1'b0;
                    IF_IDWrite = 1'b0;
                    Stall      = 1'b1;
                    Busy       = 1'b1;
                    cnt_nxt    = cnt - 2'd1;
                    // cnt<=1 also recovers from an unreachable cnt==0.
                    if (cnt <= 2'd1) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    // State, down-counter and saturating performance counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RUN;
            cnt         <= 2'd0;
            StallCycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (Stall && (StallCycles != {CNT_W{1'b1}})) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
        end
    end

endmodule
